lm70_spi_reader: RTL
====================

Name: lm70_spi_reader

Overview:
- Synchronous SPI master that reads one 16-bit frame from the LM70 temperature sensor on request.
- Drives CS and SCK and samples SIO.
- Presents the raw frame plus a signed quarter-degree temperature to the downstream control/display logic.
- Sits directly upstream of the sensor; it is the only consumer of SIO.

Parameters:
- CLK_DIV, 4, CLK cycles per SCK half-period and CS setup time (legal range 1..255).
- MIN_IDLE, 2, minimum CLK cycles CS stays high between frames (legal range 1..255).
- FRAME_W, 16, bits per sensor frame.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  level/pulse request; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until the cycle after done.
- done  output  1  one-cycle pulse when a frame completes.
- temp_raw  output  16  last complete frame, MSB first as received.
- temp_q  output  11  signed temperature in 0.25 degC units, equal to temp_raw[15:5].
- temp_valid  output  1  sticky; set on first done, cleared only by reset.
- CS  output  1  sensor chip select, active low.
- SCK  output  1  serial clock, idle low.
- SIO  input  1  serial data from sensor.

Behaviour:
- Reset (async, RST_N=0), all values immediate:
  - CS=1, SCK=0, busy=0, done=0, temp_raw=0, temp_q=0, temp_valid=0.
  - State IDLE; idle counter preloaded so a start is accepted immediately after reset release.
- Sensor contract:
  - Sensor presents its MSB on SIO as soon as CS falls.
  - Sensor shifts on each SCK falling edge while CS=0.
  - Master samples SIO at the CLK edge that drives SCK 0->1.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, DONE.
- IDLE:
  - CS=1, SCK=0.
  - If start=1 and idle_cnt>=MIN_IDLE: next state SETUP, CS->0, busy->1, div_cnt=0, bit_cnt=0.
- SETUP:
  - CS=0, SCK=0 for CLK_DIV cycles.
  - Then SCK->1, sample SIO into shift_reg LSB (shift left), next state SHIFT_HI.
- SHIFT_HI:
  - SCK=1 for CLK_DIV cycles.
  - Then SCK->0, bit_cnt+1, next state SHIFT_LO.
- SHIFT_LO:
  - SCK=0 for CLK_DIV cycles.
  - If bit_cnt<FRAME_W: SCK->1, sample SIO, next state SHIFT_HI.
  - Else next state DONE.
- DONE (one cycle):
  - CS->1, temp_raw<=shift_reg, done=1, temp_valid<=1, idle_cnt=0.
  - Next state IDLE; busy drops on the following cycle.
- Timing for start sampled at edge T0:
  - CS low from T0+1 through T0+33*CLK_DIV inclusive.
  - done high in cycle T0+1+33*CLK_DIV.
  - Exactly 16 SCK rising and 16 SCK falling edges per frame.
  - SCK is always low when CS changes.
- Counters:
  - div_cnt is 8 bits.
  - bit_cnt is 5 bits.
  - idle_cnt is 8 bits, saturates at MIN_IDLE.
- start while busy: ignored, not queued.
- start held high continuously: back-to-back frames, with CS high for exactly MIN_IDLE cycles between frames.
- RST_N asserted mid-frame: immediate abort, CS=1, SCK=0, partial data discarded, no done pulse.
- temp_raw and temp_q change only in the DONE cycle and are stable otherwise.
- temp_q is a pure slice of temp_raw with sign preserved; no rounding.

Decomposition:
- Package lm70_pkg:
  - FRAME_W.
  - TEMP_W=11.
  - TEMP_LSB_POS=5.
  - FSM state enum.
  - Bench constant TEMP_SET=16'h44C0.
- Optional sub-module lm70_sck_div: half-period counter producing tick on reaching CLK_DIV-1, with sync clear from the FSM.
- Shift register and FSM stay in the top module.

Test Plan:
- CLK_DIV=4, MIN_IDLE=2, sensor preset 16'h44C0, single start pulse:
  - 16 SCK rising edges observed.
  - done exactly at T0+133.
  - temp_raw=16'h44C0, temp_q=11'h226 (137.5 degC), temp_valid=1.
- Sensor preset 16'hF380:
  - temp_raw=16'hF380.
  - temp_q=11'h79C (-25.00 degC, i.e. -100 quarter-degrees).
- start pulsed again at T0+20 and T0+60 while busy: ignored; exactly one done, one CS low window of 132 cycles.
- start held high for 3 frames:
  - three done pulses, each read returns 16'h44C0.
  - CS high for exactly 2 cycles between frames.
- RST_N low at T0+50 mid-frame:
  - CS=1 and SCK=0 asynchronously.
  - no done; temp_valid=0.
  - next start after release completes normally with 16'h44C0.
- CLK_DIV=1:
  - done at T0+34.
  - SCK period 2 CLK cycles, high and low 1 cycle each.
  - temp_raw=16'h44C0.

Source files
------------

// File: rtl/lm70_pkg.sv
// Shared constants and FSM encoding for the LM70 SPI temperature reader.
package lm70_pkg;

    localparam int unsigned FRAME_W      = 16;
    localparam int unsigned TEMP_W       = 11;
    localparam int unsigned TEMP_LSB_POS = 5;

    // Known sensor word used by benches: +137.5 degC
    localparam logic [FRAME_W-1:0] TEMP_SET = 16'h44C0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_DONE
    } lm70_state_e;

endpackage

// File: rtl/lm70_sck_div.sv
// Half-period counter: tick marks the last CLK cycle of a CS-setup or SCK phase.
module lm70_sck_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_q;
    logic [7:0] div_cnt_d;

    // Count up, restarting whenever the FSM closes a phase or sits outside a frame
    always_comb begin
        div_cnt_d = clr ? 8'd0 : div_cnt_q + 8'd1;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= 8'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = (div_cnt_q == LAST_CNT);

endmodule

// File: rtl/lm70_spi_reader.sv
// SPI master reading one 16-bit LM70 frame per request; publishes raw frame
// and signed quarter-degree temperature.
module lm70_spi_reader
    import lm70_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned MIN_IDLE = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] temp_raw,
    output logic [TEMP_W-1:0]  temp_q,
    output logic               temp_valid,
    output logic               CS,
    output logic               SCK,
    input  logic               SIO
);
    localparam logic [4:0] BITS_PER_FRAME = 5'(FRAME_W);
    localparam logic [7:0] IDLE_SAT       = 8'(MIN_IDLE);

    lm70_state_e        state_q, state_d;
    logic               tick, div_clr, idle_ok, active_d, sample;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         idle_cnt_q, idle_cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] temp_raw_q, temp_raw_d;
    logic               temp_valid_q, temp_valid_d;
    logic               cs_q, cs_d, sck_q, sck_d;
    logic               busy_q, busy_d, done_q, done_d;

    // idle_cnt holds CS-high cycles already elapsed (DONE included); the current
    // IDLE cycle is one more, so the gap between frames is exactly MIN_IDLE.
    assign idle_ok = ({1'b0, idle_cnt_q} + 9'd1) >= {1'b0, IDLE_SAT};
    assign div_clr = (state_q == ST_IDLE) || (state_q == ST_DONE) || tick;

    lm70_sck_div #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_div (
        .clk  (CLK),
        .rst_n(RST_N),
        .clr  (div_clr),
        .tick (tick)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: each active phase lasts CLK_DIV cycles
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start && idle_ok) state_d = ST_SETUP;
            ST_SETUP:    if (tick) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: if (tick) state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: if (tick) state_d = (bit_cnt_q < BITS_PER_FRAME) ? ST_SHIFT_HI : ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values, registered so pins never glitch
    always_comb begin
        active_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT_HI) || (state_d == ST_SHIFT_LO);
        cs_d     = ~active_d;
        sck_d    = (state_d == ST_SHIFT_HI);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);

        // SIO is captured on the same edge that raises SCK
        sample  = (state_d == ST_SHIFT_HI) && (state_q != ST_SHIFT_HI);
        shift_d = shift_q;
        if (sample) shift_d = {shift_q[FRAME_W-2:0], SIO};

        bit_cnt_d = bit_cnt_q;
        if (state_q == ST_IDLE) begin
            bit_cnt_d = 5'd0;
        end else if ((state_q == ST_SHIFT_HI) && tick) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
        end

        idle_cnt_d = idle_cnt_q;
        if (state_d == ST_DONE) begin
            idle_cnt_d = 8'd0;
        end else if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && (idle_cnt_q < IDLE_SAT)) begin
            idle_cnt_d = idle_cnt_q + 8'd1;
        end

        temp_raw_d   = (state_d == ST_DONE) ? shift_q : temp_raw_q;
        temp_valid_d = temp_valid_q | (state_d == ST_DONE);
    end

    // Datapath and output registers; reset aborts any frame in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt_q    <= 5'd0;
            idle_cnt_q   <= IDLE_SAT;
            shift_q      <= '0;
            temp_raw_q   <= '0;
            temp_valid_q <= 1'b0;
            cs_q         <= 1'b1;
            sck_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            shift_q      <= shift_d;
            temp_raw_q   <= temp_raw_d;
            temp_valid_q <= temp_valid_d;
            cs_q         <= cs_d;
            sck_q        <= sck_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign CS         = cs_q;
    assign SCK        = sck_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign temp_raw   = temp_raw_q;
    assign temp_valid = temp_valid_q;
    assign temp_q     = temp_raw_q[TEMP_LSB_POS +: TEMP_W];

endmodule
